// File: rtl/seven_seg_scanner_pkg.sv
// Shared types for the display path: BCD digit type and the blank code
// understood by the downstream seven-segment decoder.
package seven_seg_scanner_pkg;

  localparam logic [3:0] SEG_BLANK = 4'hF;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot-rate prescaler: counts 0..TICK_DIV-1 and flags the last count as tick.
module scan_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner with frame-coherent shadow digits and active-low drives.
// Optional digit blinking is built when SEVEN_SEG_SCAN_BLINK_EN is defined.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int TICK_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  load,
  output logic [3:0]            num,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IW = $clog2(N_DIGITS);

  logic                         tick;
  logic                         wrap;
  logic                         started;
  logic                         pending;
  logic                         blank_nxt;
  logic [IW-1:0]                idx;
  logic [IW-1:0]                next_idx;
  bcd_t [N_DIGITS-1:0]          staging;
  bcd_t [N_DIGITS-1:0]          shadow;
  bcd_t [N_DIGITS-1:0]          shadow_nxt;
  logic [N_DIGITS-1:0]          staging_dp;
  logic [N_DIGITS-1:0]          shadow_dp;
  logic [N_DIGITS-1:0]          shadow_dp_nxt;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wrap     = tick && (idx == IW'(N_DIGITS - 1));
  assign next_idx = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);

  // A load landing on the wrap tick goes straight into the new frame.
  always_comb begin
    shadow_nxt    = shadow;
    shadow_dp_nxt = shadow_dp;
    if (wrap && load) begin
      shadow_nxt    = digits_in;
      shadow_dp_nxt = dp_in;
    end else if (wrap && pending) begin
      shadow_nxt    = staging;
      shadow_dp_nxt = staging_dp;
    end
  end

`ifdef SEVEN_SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] fcnt;
  logic          fcnt_last;
  logic          phase;
  logic          phase_nxt;

  assign fcnt_last = (fcnt == FW'(BLINK_FRAMES - 1));
  assign phase_nxt = (wrap && fcnt_last) ? ~phase : phase;
  assign blank_nxt = phase_nxt & blink_mask[next_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      fcnt  <= fcnt_last ? '0 : fcnt + FW'(1);
      phase <= phase_nxt;
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink;

  assign unused_blink = ^blink_mask;
  assign blank_nxt    = 1'b0;
`endif

  // Each slot opens with one all-off anode cycle so the new code settles dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      started    <= 1'b0;
      pending    <= 1'b0;
      staging    <= {N_DIGITS{SEG_BLANK}};
      staging_dp <= '0;
      shadow     <= {N_DIGITS{SEG_BLANK}};
      shadow_dp  <= '0;
      an         <= '1;
      num        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (load && !wrap) begin
        staging    <= digits_in;
        staging_dp <= dp_in;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      shadow     <= shadow_nxt;
      shadow_dp  <= shadow_dp_nxt;
      frame_done <= wrap;
      if (tick) begin
        idx     <= next_idx;
        started <= 1'b1;
        an      <= '1;
        num     <= blank_nxt ? SEG_BLANK : shadow_nxt[next_idx];
        dp      <= blank_nxt ? 1'b1 : ~shadow_dp_nxt[next_idx];
      end else if (started) begin
        an <= ~(N_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner against a slot/frame
// arithmetic model. Honours SEVEN_SEG_SCAN_BLINK_EN like the design.
module tb_seven_seg_scanner;

  localparam int N     = 6;
  localparam int TD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * TD;
  localparam int MAXC  = 4096;
`ifdef SEVEN_SEG_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blink_mask;
  logic [3:0]    num;
  logic [N-1:0]  an;
  logic          dp;
  logic          frame_done;

  int compared   = 0;
  int mismatched = 0;
  int t          = 0;
  logic [N-1:0] curMask = '0;

  logic           loadHist [MAXC];
  logic [4*N-1:0] digHist  [MAXC];
  logic [N-1:0]   dpHist   [MAXC];
  logic [N-1:0]   maskHist [MAXC];

  seven_seg_scanner #(
    .N_DIGITS     (N),
    .TICK_DIV     (TD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .load       (load),
    .num        (num),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, observed, expected);
    end
  endtask

  // Cycle t since reset: slot s = t/TD, digit s%N, frame s/N. Slot 0 is dark.
  // Frame f shows the most recent load taken at or before cycle f*FRAME-1.
  task automatic checkModel();
    int s, p, d, f, lim;
    logic [4*N-1:0] dg;
    logic [N-1:0] dpv;
    logic blank;
    logic [N-1:0] expAn;
    logic [3:0] expNum;
    logic expDp, expFd;
    s = t / TD;
    p = t % TD;
    if (s == 0) begin
      expAn = '1; expNum = 4'hF; expDp = 1'b1; expFd = 1'b0;
    end else begin
      d = s % N;
      f = s / N;
      expAn = (p == 0) ? '1 : ~(N'(1) << d);
      expFd = (p == 0) && (d == 0);
      dg  = {N{4'hF}};
      dpv = '0;
      lim = f * FRAME - 1;
      for (int i = 0; i <= lim && i < t; i++) begin
        if (loadHist[i]) begin
          dg  = digHist[i];
          dpv = dpHist[i];
        end
      end
      blank  = BLINK && ((f / BF) % 2 == 1) && maskHist[s*TD-1][d];
      expNum = blank ? 4'hF : dg[4*d +: 4];
      expDp  = blank ? 1'b1 : ~dpv[d];
    end
    checkOutput("an", 32'(an), 32'(expAn));
    checkOutput("num", 32'(num), 32'(expNum));
    checkOutput("dp", 32'(dp), 32'(expDp));
    checkOutput("frame_done", 32'(frame_done), 32'(expFd));
  endtask

  task automatic applyStimulus(input logic doRst, input logic doLoad,
                               input logic [4*N-1:0] dg, input logic [N-1:0] dps);
    @(negedge clk);
    checkModel();
    rst        = doRst;
    load       = doLoad;
    digits_in  = dg;
    dp_in      = dps;
    blink_mask = curMask;
    if (doRst) begin
      t = 0;
    end else if (t >= MAXC - 1) begin
      $display("[TB] FAIL history_bound at cycle %0d: got %0d, expected < %0d", t, t, MAXC - 1);
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] history overflow");
    end else begin
      loadHist[t] = doLoad;
      digHist[t]  = dg;
      dpHist[t]   = dps;
      maskHist[t] = curMask;
      t++;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic runTo(input int m);
    for (int i = 0; i < FRAME && (t % FRAME) != m; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blink_mask = '0;
    repeat (2) @(posedge clk);
    t = 0;

    idle(2 * FRAME);

    runTo(5);
    applyStimulus(1'b0, 1'b1, 24'h123456, 6'b000100);
    idle(2 * FRAME);

    runTo(3);
    applyStimulus(1'b0, 1'b1, 24'h987654, 6'b111111);
    runTo(10);
    applyStimulus(1'b0, 1'b1, 24'h0AB1C2, 6'b010010);
    idle(2 * FRAME);

    runTo(FRAME - 1);
    applyStimulus(1'b0, 1'b1, 24'h246802, 6'b100001);
    idle(FRAME + 2);

    runTo(7);
    applyStimulus(1'b0, 1'b1, 24'h135791, 6'b001000);
    runTo(FRAME - 1);
    applyStimulus(1'b0, 1'b1, 24'hEDCBA9, 6'b000010);
    idle(FRAME + 2);

    applyStimulus(1'b1, 1'b0, '0, '0);
    curMask = 6'b000100;
    runTo(9);
    applyStimulus(1'b0, 1'b1, 24'h654321, 6'b000000);
    idle(6 * FRAME);

    for (int i = 0; i < 15 * FRAME; i++) begin
      if (i % FRAME == 0) curMask = N'($urandom);
      if ($urandom_range(0, 299) == 0)
        applyStimulus(1'b1, 1'b0, '0, '0);
      else
        applyStimulus(1'b0, ($urandom_range(0, 7) == 0), 24'($urandom), N'($urandom));
    end

    curMask = '0;
    applyStimulus(1'b1, 1'b0, '0, '0);
    idle(FRAME);
    runTo(2);
    applyStimulus(1'b0, 1'b1, 24'h777777, 6'b111111);
    runTo(13);
    applyStimulus(1'b1, 1'b0, '0, '0);
    idle(3 * FRAME);

    @(negedge clk);
    checkModel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed display scanner for the alarm-clock front panel. Holds a frame-coherent shadow copy of the BCD digits from the clock/alarm datapath, steps through the digits at a fixed refresh rate, and presents one BCD code per slot to the combinational seven-segment decoder together with the active-low anode and decimal-point drives. Sits directly upstream of the decoder; its `num` output feeds the decoder's `num` input.

## Interface
- `N_DIGITS`, 6, number of digits scanned (HH:MM:SS); legal range 2..8
- `TICK_DIV`, 100000, clock cycles per digit slot; legal minimum 3 (1 kHz slot rate at 100 MHz)
- `BLINK_FRAMES`, 125, full frames per blink half-period; legal minimum 1
- `clk` in 1 — system clock; the block has one clock
- `rst` in 1 — synchronous, active-high reset
- `digits_in` in 4*N_DIGITS — BCD digit i at [4i+3:4i]; digit 0 is rightmost
- `dp_in` in N_DIGITS — decimal point request per digit, active-high
- `blink_mask` in N_DIGITS — digits to blink (setting mode)
- `load` in 1 — one-cycle strobe: capture `digits_in`/`dp_in` for display
- `num` out 4 — BCD code to the decoder; 4'hF = blank
- `an` out N_DIGITS — anode enables, active-low one-hot
- `dp` out 1 — decimal point, active-low
- `frame_done` out 1 — one-cycle pulse at start of each frame

## Operation
- Prescaler `cnt` counts 0..TICK_DIV-1, wraps; `tick` = (`cnt` == TICK_DIV-1).
- Slot index `idx` advances on `tick`: N_DIGITS-1 -> 0 is the frame wrap.
- Load path: `load` captures `digits_in`/`dp_in` into a staging register and sets `pending`. On a frame-wrap tick with `pending` set, staging -> shadow, `pending` clears. Repeated loads before the wrap: last wins. A `load` on the same cycle as the wrap tick is bypassed straight into shadow for the new frame; `pending` stays clear.
- Display uses shadow only; mid-frame `load` never changes the current frame.
- Codes 10..14 pass through unchanged (decoder blanks them).
- Blink (see Configuration): when `phase`=1 and `blink_mask[idx]`=1, `num` is forced to 4'hF and `dp` to 1; `an` still scans.
- All outputs are registered.

## Timing
- Reset values: `cnt`=0, `idx`=0, `an`=all ones, `num`=4'hF, `dp`=1, `frame_done`=0, shadow and staging digits=4'hF, shadow dp=0, `pending`=0, `phase`=0, frame counter=0. Display is dark until the first tick.
- Cycle T = tick: at T+1, `idx`=next, `num`/`dp` = new digit, `an`=all ones (one-cycle anti-ghost blank). At T+2 through the next tick, `an` has bit `idx` low.
- `frame_done` is high at T+1 of the wrap tick only.
- `rst` asserted mid-slot: all state returns to reset values the next cycle; the pending load is discarded.
- Load to visible: at most one frame plus two cycles.

## Configuration
- `SEVEN_SEG_SCAN_BLINK_EN` defined: frame counter counts wraps 0..BLINK_FRAMES-1. `phase` toggles on the wrap that ends count BLINK_FRAMES-1. Masked digits blank while `phase`=1.
- Undefined: no frame counter or `phase` logic; `blink_mask` is kept as a port but ignored; all digits are always shown.

## Structure
- Shared package holds the blank code constant `SEG_BLANK` = 4'hF and the BCD digit typedef (4-bit), shared with the decoder.
- One sub-module: `scan_tick_gen`, the TICK_DIV prescaler emitting `tick`. Everything else lives in `seven_seg_scanner`.

## Test plan
All scenarios use N_DIGITS=6, TICK_DIV=4, BLINK_FRAMES=2.
- Reset, no load: `an`=6'b111111, `num`=F, `dp`=1 at release. After the first tick, `an` cycles through 111110…011111 and `num` is always F.
- Load digits 1,2,3,4,5,6 (digit0=6), `dp_in`=6'b000100, mid-frame: current frame is unchanged. Next frame `num` runs 6,5,4,3,2,1 at 4 cycles per slot, each slot starting with one `an`=all-ones cycle. `dp`=0 only in slot 2.
- Two loads in one frame (values A, then B): only B appears next frame. A is never shown.
- Load coincident with the wrap tick: the new value is shown from slot 0 of the starting frame. `frame_done` pulses once, at T+1.
- With blink enabled, `blink_mask`=6'b000100: slot 2 shows its digit in frames 0–1, F in frames 2–3, and the digit again in frames 4–5. With the macro undefined, slot 2 always shows the digit.
- `rst` pulsed during slot 3 with a load pending: outputs return to reset values the next cycle, and the pending value never displays.
